// File: rtl/aes_pkg.sv
// AES shared types and GF(2^8) helpers (poly 0x11B), used by the
// decrypt-side InvMixColumns engine and the encrypt-side Mult2/Mult3 users.
package aes_pkg;

   typedef logic [0:127] state_t;
   typedef logic [0:31]  col_t;
   typedef logic [7:0]   byte_t;

   typedef enum logic [1:0] {
      IMC_IDLE,
      IMC_BUSY,
      IMC_DONE
   } imc_state_e;

   localparam byte_t GF_POLY = 8'h1b;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   function automatic byte_t gmul9(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ a;
   endfunction

   function automatic byte_t gmul11(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ a;
   endfunction

   function automatic byte_t gmul13(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ a;
   endfunction

   function automatic byte_t gmul14(input byte_t a);
      byte_t x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/inv_mix_column_comb.sv
// Combinational InvMixColumns of one 32-bit column.
// Ports: i_col column in (byte 0 at MSB), o_col transformed column.
module inv_mix_column_comb
   import aes_pkg::*;
(
   input  logic [0:31] i_col,
   output logic [0:31] o_col
);

   byte_t w_a0, w_a1, w_a2, w_a3;

   assign w_a0 = i_col[0:7];
   assign w_a1 = i_col[8:15];
   assign w_a2 = i_col[16:23];
   assign w_a3 = i_col[24:31];

   assign o_col = {
      gmul14(w_a0) ^ gmul11(w_a1) ^ gmul13(w_a2) ^ gmul9(w_a3),
      gmul9(w_a0)  ^ gmul14(w_a1) ^ gmul11(w_a2) ^ gmul13(w_a3),
      gmul13(w_a0) ^ gmul9(w_a1)  ^ gmul14(w_a2) ^ gmul11(w_a3),
      gmul11(w_a0) ^ gmul13(w_a1) ^ gmul9(w_a2)  ^ gmul14(w_a3)
   };

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns, COLS_PER_CYCLE (1/2/4) columns per clock.
// Ports: clk, rst (async high), in_valid/in_ready/in_state,
// out_valid/out_ready/out_state. INV_MIX_BYPASS_EN adds bypass input.
module inv_mix_columns_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_state,
`ifdef INV_MIX_BYPASS_EN
   input  logic         bypass,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_state
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
       COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   imc_state_e r_state;
   imc_state_e w_state_nxt;
   state_t     r_work;
   logic [1:0] r_col_cnt;
   logic       w_load;
   logic       w_step;
   logic       w_last;
`ifdef INV_MIX_BYPASS_EN
   logic       r_bypass;
`endif

   logic [1:0]  w_idx     [COLS_PER_CYCLE];
   logic [0:31] w_col_in  [COLS_PER_CYCLE];
   logic [0:31] w_col_out [COLS_PER_CYCLE];
   logic [0:31] w_col_res [COLS_PER_CYCLE];

   // Last step is the one whose column group ends at column 3.
   assign w_last = (r_col_cnt == 2'(4 - COLS_PER_CYCLE));

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      assign w_idx[k]    = r_col_cnt + 2'(k);
      assign w_col_in[k] = r_work[{w_idx[k], 5'b0} +: 32];
      inv_mix_column_comb u_col (
         .i_col (w_col_in[k]),
         .o_col (w_col_out[k])
      );
`ifdef INV_MIX_BYPASS_EN
      assign w_col_res[k] = r_bypass ? w_col_in[k] : w_col_out[k];
`else
      assign w_col_res[k] = w_col_out[k];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IMC_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IMC_IDLE: if (in_valid) w_state_nxt = IMC_BUSY;
         IMC_BUSY: if (w_last) w_state_nxt = IMC_DONE;
         IMC_DONE: begin
            if (out_ready) begin
               w_state_nxt = in_valid ? IMC_BUSY : IMC_IDLE;
            end
         end
         default: w_state_nxt = IMC_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_step    = 1'b0;
      unique case (r_state)
         IMC_IDLE: in_ready = ~rst;
         IMC_BUSY: w_step = 1'b1;
         IMC_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
      w_load = in_valid & in_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work    <= '0;
         r_col_cnt <= '0;
`ifdef INV_MIX_BYPASS_EN
         r_bypass  <= 1'b0;
`endif
      end else if (w_load) begin
         r_work    <= in_state;
         r_col_cnt <= '0;
`ifdef INV_MIX_BYPASS_EN
         r_bypass  <= bypass;
`endif
      end else if (w_step) begin
         for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            r_work[{w_idx[k], 5'b0} +: 32] <= w_col_res[k];
         end
         r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
      end
   end

   assign out_state = r_work;

endmodule
